branch_order_scheduler: RTL

BRANCH_ORDER_SCHEDULER -- requirements
Module: branch_order_scheduler

---
 rtl/branch_order_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/branch_order_scheduler.sv
// In-order branch resolution tracker: holds in-flight branches in a circular buffer,
// retires them in allocation order to update the predictor, and halts on a mispredict until flush.
module branch_order_scheduler #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alloc_valid,
  input  logic [3:0]  alloc_tag,
  input  logic        alloc_pred,
  input  logic [2:0]  alloc_idx,
  output logic        alloc_ready,
  input  logic [73:0] cdb,
  input  logic        flush,
  output logic        upd_valid,
  output logic [2:0]  upd_idx,
  output logic        upd_taken,
  output logic        mispredict,
  output logic [3:0]  mispredict_tag,
  output logic [3:0]  occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {
    RUN        = 1'b0,
    WAIT_FLUSH = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_res;
  logic [DEPTH-1:0] ent_pred;
  logic [DEPTH-1:0] ent_out;
  logic [3:0]       ent_tag [DEPTH];
  logic [2:0]       ent_idx [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic             cdb_vld;
  logic [3:0]       cdb_tag;
  logic             cdb_taken;
  logic             cdb_unused;

  logic             run;
  logic             do_alloc;
  logic             do_retire;
  logic             retire_mis;
  logic             res_hit;
  logic [PTR_W-1:0] res_ptr;
  logic [PTR_W-1:0] scan_ptr;

  assign cdb_vld    = cdb[36];
  assign cdb_tag    = cdb[35:32];
  assign cdb_taken  = cdb[0];
  assign cdb_unused = ^{cdb[73:37], cdb[31:1]};

  assign run         = (state == RUN);
  assign alloc_ready = run && (count < DEPTH_C);
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_retire   = run && ent_valid[head] && ent_res[head];
  assign retire_mis  = ent_out[head] != ent_pred[head];
  assign occupancy   = count;

  // Scan youngest to oldest so the last hit kept is the oldest matching entry.
  always_comb begin
    res_hit  = 1'b0;
    res_ptr  = '0;
    scan_ptr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      scan_ptr = head + PTR_W'(i);
      if (run && cdb_vld && ent_valid[scan_ptr] && !ent_res[scan_ptr] &&
          (ent_tag[scan_ptr] == cdb_tag)) begin
        res_hit = 1'b1;
        res_ptr = scan_ptr;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:        if (do_retire && retire_mis) state_next = WAIT_FLUSH;
      WAIT_FLUSH: state_next = WAIT_FLUSH;
      default:    state_next = RUN;
    endcase
    if (flush) state_next = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Entry storage and pointers; resolve, retire and allocate never target the
  // same slot on one edge because only unresolved entries resolve and the tail
  // is never the live head while space remains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      ent_res   <= '0;
      ent_pred  <= '0;
      ent_out   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_tag[i] <= '0;
        ent_idx[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      ent_valid <= '0;
      ent_res   <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (res_hit) begin
        ent_res[res_ptr] <= 1'b1;
        ent_out[res_ptr] <= cdb_taken;
      end
      if (do_retire) begin
        ent_valid[head] <= 1'b0;
        ent_res[head]   <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (do_alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_res[tail]   <= 1'b0;
        ent_tag[tail]   <= alloc_tag;
        ent_pred[tail]  <= alloc_pred;
        ent_idx[tail]   <= alloc_idx;
        tail            <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(do_alloc) - CNT_W'(do_retire);
    end
  end

  // Retire result register: pulses last exactly one cycle per retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid      <= 1'b0;
      upd_idx        <= '0;
      upd_taken      <= 1'b0;
      mispredict     <= 1'b0;
      mispredict_tag <= '0;
    end else if (flush) begin
      upd_valid  <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      upd_valid  <= do_retire;
      mispredict <= do_retire && retire_mis;
      if (do_retire) begin
        upd_idx   <= ent_idx[head];
        upd_taken <= ent_out[head];
        if (retire_mis) mispredict_tag <= ent_tag[head];
      end
    end
  end

endmodule
